// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default timing constants,
// used by both the transmit and receive paths.
package uart_pkg;

  localparam int DEF_OVERSAMPLE = 16;
  localparam int DEF_BAUD_DIV   = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_rx_baud_tick.sv
// Oversample tick generator: counts 0..BAUD_DIV-1 and strobes tick on the
// last count. A synchronous clear realigns the phase to a start edge.
module uart_rx_baud_tick #(
  parameter int BAUD_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  assign tick = !clr && (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1 (8E1 when UART_RX_PARITY_EN is defined) with 16x
// oversampling, centre sampling and registered one-cycle result pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int BAUD_DIV   = DEF_BAUD_DIV,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int DATA_BITS  = 8
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Rx,
  output logic [DATA_BITS-1:0] Data,
  output logic                 Data_Valid,
  output logic                 Frame_Error,
  output logic                 Parity_Error,
  output logic                 Busy,
  output logic [2:0]           Dbg_State
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  uart_state_e state_q, state_d;

  logic [1:0]           sync_q, sync_d;
  logic [TW-1:0]        tcnt_q, tcnt_d;
  logic [BW-1:0]        bidx_q, bidx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 dv_q, dv_d;
  logic                 fe_q, fe_d;
  logic                 rx_s;
  logic                 tick;
  logic                 sample;

`ifdef UART_RX_PARITY_EN
  logic perr_q, perr_d;
  logic pe_q, pe_d;
`endif

  assign sync_d = {sync_q[0], Rx};
  assign rx_s   = sync_q[1];

  uart_rx_baud_tick #(
    .BAUD_DIV(BAUD_DIV)
  ) u_tick (
    .clk  (Clk),
    .rst_n(Reset),
    .clr  (state_q == ST_IDLE),
    .tick (tick)
  );

  // The start bit is sampled half a bit in; every later bit one full bit after.
  assign sample = tick && ((state_q == ST_START) ? (tcnt_q == HALF_LAST)
                                                 : (tcnt_q == FULL_LAST));

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (!rx_s) state_d = ST_START;
      ST_START: if (sample) state_d = rx_s ? ST_IDLE : ST_DATA;
      ST_DATA: begin
        if (sample && (bidx_q == BIT_LAST)) begin
`ifdef UART_RX_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = ST_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: if (sample) state_d = ST_STOP;
`endif
      ST_STOP:  if (sample) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tcnt_d  = tcnt_q;
    bidx_d  = bidx_q;
    shift_d = shift_q;
    data_d  = data_q;
    dv_d    = 1'b0;
    fe_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d  = perr_q;
    pe_d    = 1'b0;
`endif
    if (state_q == ST_IDLE) begin
      tcnt_d = '0;
      bidx_d = '0;
`ifdef UART_RX_PARITY_EN
      perr_d = 1'b0;
`endif
    end else if (tick) begin
      tcnt_d = sample ? '0 : tcnt_q + TW'(1);
    end

    if (sample && (state_q == ST_DATA)) begin
      for (int i = 0; i < DATA_BITS; i++) begin
        if (bidx_q == BW'(i)) shift_d[i] = rx_s;
      end
      bidx_d = bidx_q + BW'(1);
    end

`ifdef UART_RX_PARITY_EN
    if (sample && (state_q == ST_PARITY)) begin
      perr_d = rx_s != (^shift_q);
    end
`endif

    // A bad stop bit outranks a parity mismatch; Data only moves on a clean frame.
    if (sample && (state_q == ST_STOP)) begin
      if (!rx_s) begin
        fe_d = 1'b1;
`ifdef UART_RX_PARITY_EN
      end else if (perr_q) begin
        pe_d = 1'b1;
`endif
      end else begin
        dv_d   = 1'b1;
        data_d = shift_q;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      sync_q  <= 2'b11;
      tcnt_q  <= '0;
      bidx_q  <= '0;
      shift_q <= '0;
      data_q  <= '0;
      dv_q    <= 1'b0;
      fe_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q  <= 1'b0;
      pe_q    <= 1'b0;
`endif
    end else begin
      sync_q  <= sync_d;
      tcnt_q  <= tcnt_d;
      bidx_q  <= bidx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      fe_q    <= fe_d;
`ifdef UART_RX_PARITY_EN
      perr_q  <= perr_d;
      pe_q    <= pe_d;
`endif
    end
  end

  assign Data        = data_q;
  assign Data_Valid  = dv_q;
  assign Frame_Error = fe_q;
  assign Busy        = (state_q != ST_IDLE);
  assign Dbg_State   = state_q;
`ifdef UART_RX_PARITY_EN
  assign Parity_Error = pe_q;
`else
  assign Parity_Error = 1'b0;
`endif

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receive stage of the UART: the counterpart of the transmit path, consuming the line the transmitter drives. It samples an asynchronous 8N1 serial input with 16x oversampling, validates start and stop bits, and presents each received byte on a parallel bus with a one-cycle valid pulse for the downstream host logic.

## Interface
- BAUD_DIV, 4: Clk cycles per oversample tick (≥2); bit period = BAUD_DIV*OVERSAMPLE cycles.
- OVERSAMPLE, 16: ticks per bit (even, ≥4).
- DATA_BITS, 8: payload bits per frame, LSB first.

Ports:
- Clk  input  1  system clock; all logic on rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Rx  input  1  serial line, idle high, asynchronous to Clk.
- Data  output  DATA_BITS  last good byte; reset 0.
- Data_Valid  output  1  one-cycle pulse when Data updates; reset 0.
- Frame_Error  output  1  one-cycle pulse on bad stop bit; reset 0.
- Parity_Error  output  1  one-cycle pulse on parity mismatch; reset 0, tied 0 without UART_RX_PARITY_EN.
- Busy  output  1  high in every state except IDLE; reset 0.

## Operation
- Rx passes through a 2-flop synchronizer (reset value 1) before any use; the sync output is called rx_s.
- States: IDLE, START, DATA, PARITY (only with macro), STOP.
- IDLE: on rx_s = 0 go to START; tick divider and tick counter cleared the same cycle.
- START: after OVERSAMPLE/2 ticks sample rx_s; 0 → DATA, tick counter cleared; 1 → IDLE (false start, no output pulse).
- DATA: every OVERSAMPLE ticks sample rx_s into shift register bit position = bit index (LSB first); after DATA_BITS samples go to PARITY or STOP.
- PARITY: after OVERSAMPLE ticks sample rx_s; compare with even parity of the payload; mismatch latched, go to STOP.
- STOP: after OVERSAMPLE ticks sample rx_s. If 1 and no parity mismatch: Data ← shift register, Data_Valid pulse. If 1 with mismatch: Parity_Error pulse, Data unchanged. If 0: Frame_Error pulse only (a frame error takes precedence over a parity error), Data unchanged. Always return to IDLE immediately (mid-stop-bit), so a start edge half a bit later is caught.
- Only one of Data_Valid / Frame_Error / Parity_Error is high in any cycle.
- Reset asserted mid-frame: all state, counters, and outputs return to their reset values asynchronously; the partial frame is discarded. After release, a line held low is treated as a new start edge.

## Timing
- Tick: one-cycle strobe every BAUD_DIV cycles from a divider that counts 0..BAUD_DIV-1.
- Sync latency: 2 cycles from Rx to rx_s.
- Samples are taken at bit centres: start at OVERSAMPLE/2 ticks, each later bit OVERSAMPLE ticks after the previous sample.
- Output pulses are registered: high for exactly the one cycle after the stop-sample tick.
- Start-edge-to-Data_Valid latency = 2 + (DATA_BITS+1)*BAUD_DIV*OVERSAMPLE + BAUD_DIV*OVERSAMPLE/2 + 1 cycles (add BAUD_DIV*OVERSAMPLE with parity); 611 cycles at defaults.
- Tick counter width: clog2(OVERSAMPLE); bit index width: clog2(DATA_BITS+1).

## Configuration
- UART_RX_PARITY_EN defined: frame is 8E1, PARITY state present, Parity_Error driven.
- Not defined: frame is 8N1, PARITY state and parity logic absent, Parity_Error constant 0.

## Structure
- Shared package uart_pkg: state encoding localparams (IDLE, START, DATA, PARITY, STOP) and the default OVERSAMPLE/BAUD_DIV constants, used by both the transmit and receive paths.
- Sub-module uart_rx_baud_tick: the BAUD_DIV divider with a synchronous clear input and a tick output. The FSM, synchronizer, and shift register stay in uart_rx.

## Test plan
- Defaults; send 0xA5 as 8N1 (64 cycles per bit) → Data=0xA5, single Data_Valid pulse 611 cycles after the falling edge, Busy low afterward.
- Low glitch of 20 cycles on idle line → no pulses; Busy high for about 32+2 cycles then back to IDLE; Data keeps its previous value.
- Send 0x3C with stop bit driven 0 → one Frame_Error pulse, no Data_Valid, Data unchanged.
- Back-to-back 0x00 then 0xFF, with the second start edge directly after the stop bit → two Data_Valid pulses, Data=0x00 then 0xFF.
- Assert Reset during bit 3 of a frame, release, then send 0x5A → all outputs 0 during reset, partial frame dropped, Data=0x5A received cleanly.
- With UART_RX_PARITY_EN: send 0x07 with parity 1 → Data_Valid, Data=0x07; send 0x07 with parity 0 → Parity_Error pulse, Data unchanged.
